axi_to_mem_rw_share: RTL and testbench
======================================

Name: axi_to_mem_rw_share

Overview:
- Successor stage for split read/write AXI-to-memory converters.
- Takes a read-side and a write-side memory request stream, each NumBanks wide, and merges them onto NumBanks shared physical bank ports.
- Per-bank arbitration is configurable. Responses are routed back to the issuing side through per-bank in-order tracking FIFOs.
- Removes the need for dual-ported banks behind a read/write-split converter.

Parameters:
NumBanks, 4, number of banks/port pairs (>=1)
AddrWidth, 32, byte address width
MemDataWidth, 64, bank data width (multiple of 8)
MaxOutstanding, 2, per-bank outstanding grants tracked (>=1); set to bank response latency
ArbMode, 0, 0 = round-robin per bank; 1 = write-priority with read starvation guard
StarveLimit, 4, ArbMode=1 only: consecutive read losses before forced read grant (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
busy_o  out  1  any request pending or any response outstanding
rd_req_i  in  NumBanks  read-side request valid
rd_gnt_o  out  NumBanks  read-side grant
rd_addr_i  in  NumBanks*AddrWidth  read-side byte address
rd_rvalid_o  out  NumBanks  read-side response valid
rd_rdata_o  out  NumBanks*MemDataWidth  read-side response data
wr_req_i  in  NumBanks  write-side request valid
wr_gnt_o  out  NumBanks  write-side grant
wr_addr_i  in  NumBanks*AddrWidth  write-side byte address
wr_wdata_i  in  NumBanks*MemDataWidth  write data
wr_strb_i  in  NumBanks*MemDataWidth/8  byte strobe
wr_atop_i  in  NumBanks*6  axi_pkg::atop_t
wr_rvalid_o  out  NumBanks  write-side response valid
wr_rdata_o  out  NumBanks*MemDataWidth  write-side response data (atomic old value)
mem_req_o  out  NumBanks  bank request
mem_gnt_i  in  NumBanks  bank grant
mem_addr_o  out  NumBanks*AddrWidth  bank address
mem_wdata_o  out  NumBanks*MemDataWidth  bank write data
mem_strb_o  out  NumBanks*MemDataWidth/8  bank strobe
mem_atop_o  out  NumBanks*6  bank atop
mem_we_o  out  NumBanks  bank write enable
mem_rvalid_i  in  NumBanks  bank response valid (one per granted request, in order, >=1 cycle after gnt)
mem_rdata_i  in  NumBanks*MemDataWidth  bank response data

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state lives in clk_i; rst_i is sampled on the rising edge only.
- Banks are fully independent; each has an arbiter, a lock, an RR/starve state and a route FIFO.
- Request protocol:
  - Inputs hold req and payload stable until granted.
  - A side's gnt = selected & mem_gnt_i & route FIFO not full.
  - mem_req_o = (rd_req|wr_req) & FIFO not full.
- Selection:
  - If the lock is set, select the locked side.
  - Else if only one side requests, select it.
  - Else if both request:
    - ArbMode 0: the side not granted last (reset: read first).
    - ArbMode 1: write, unless starve_cnt == StarveLimit, then read.
- Lock: set when mem_req_o=1 and mem_gnt_i=0, holding the current side; cleared on grant. Keeps the mem payload stable until the handshake.
- Payload:
  - Read selected: addr from rd_addr_i, we=0, wdata/strb/atop=0.
  - Write selected: we=1 and write-side payload.
- starve_cnt (ArbMode 1):
  - Increments, saturating at StarveLimit, on each write grant while rd_req_i is asserted.
  - Resets to 0 on read grant.
- Route FIFO:
  - Depth MaxOutstanding, 1 bit (0 = read, 1 = write).
  - Push on any grant; pop on mem_rvalid_i.
  - Full blocks new grants even if a pop occurs in the same cycle.
- Responses:
  - rd_rvalid_o = mem_rvalid_i & head==0; wr_rvalid_o = mem_rvalid_i & head==1.
  - Both rdata outputs carry mem_rdata_i unmasked; zero added latency.
- mem_rvalid_i with an empty FIFO is a protocol error: dropped, asserted in simulation.
- busy_o = |rd_req_i | |wr_req_i | any FIFO non-empty.
- Reset values: all gnt/rvalid/mem_req_o/mem_we_o = 0; FIFOs empty; locks clear; RR = read; starve_cnt = 0; busy_o follows the inputs.
- Reset mid-operation: outstanding tracking is discarded, and later stale rvalids are dropped. The environment must not issue new requests while rst_i=1 (gnt forced 0 during reset).

Test Plan:
1. Bank0, ArbMode 0, rd+wr both held, mem_gnt_i=1, latency 1 → grants alternate rd,wr,rd,wr; 4 responses routed accordingly; busy_o drops 1 cycle after last rvalid.
2. ArbMode 1, StarveLimit=4, both held 10 cycles, mem_gnt_i=1 → grant sequence W,W,W,W,R,W,W,W,W,R.
3. mem_gnt_i=0 for 3 cycles with rd+wr requesting, read selected first → mem_addr_o/we stay on the read payload all 3 cycles; read granted on cycle 4.
4. MaxOutstanding=2, mem_gnt_i=1, no rvalid → 2 grants, then mem_req_o=0; first rvalid re-enables requests next cycle.
5. Write atop=ATOMICADD with rdata 0x1234 returned → wr_rvalid_o=1 with wr_rdata_o=0x1234, rd_rvalid_o=0.
6. rst_i asserted with 2 outstanding, then rvalid arrives → no rd/wr rvalid, busy_o=0, next request arbitrates read-first.

Source files
------------

// File: rtl/axi_to_mem_rw_share_if.sv
// Bundle of the read-side, write-side and bank-side request/response
// signals for axi_to_mem_rw_share. The slave modport is the view of the
// merging stage; the master modport is the view of its environment.
interface axi_to_mem_rw_share_if #(
    parameter int unsigned NumBanks     = 4,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned MemDataWidth = 64
);
    localparam int unsigned StrbWidth = MemDataWidth / 8;

    logic                             busy_o;
    // read side
    logic [NumBanks-1:0]              rd_req_i;
    logic [NumBanks-1:0]              rd_gnt_o;
    logic [NumBanks*AddrWidth-1:0]    rd_addr_i;
    logic [NumBanks-1:0]              rd_rvalid_o;
    logic [NumBanks*MemDataWidth-1:0] rd_rdata_o;
    // write side
    logic [NumBanks-1:0]              wr_req_i;
    logic [NumBanks-1:0]              wr_gnt_o;
    logic [NumBanks*AddrWidth-1:0]    wr_addr_i;
    logic [NumBanks*MemDataWidth-1:0] wr_wdata_i;
    logic [NumBanks*StrbWidth-1:0]    wr_strb_i;
    logic [NumBanks*6-1:0]            wr_atop_i;
    logic [NumBanks-1:0]              wr_rvalid_o;
    logic [NumBanks*MemDataWidth-1:0] wr_rdata_o;
    // shared bank ports
    logic [NumBanks-1:0]              mem_req_o;
    logic [NumBanks-1:0]              mem_gnt_i;
    logic [NumBanks*AddrWidth-1:0]    mem_addr_o;
    logic [NumBanks*MemDataWidth-1:0] mem_wdata_o;
    logic [NumBanks*StrbWidth-1:0]    mem_strb_o;
    logic [NumBanks*6-1:0]            mem_atop_o;
    logic [NumBanks-1:0]              mem_we_o;
    logic [NumBanks-1:0]              mem_rvalid_i;
    logic [NumBanks*MemDataWidth-1:0] mem_rdata_i;

    modport slave (
        output busy_o,
        input  rd_req_i, rd_addr_i,
        output rd_gnt_o, rd_rvalid_o, rd_rdata_o,
        input  wr_req_i, wr_addr_i, wr_wdata_i, wr_strb_i, wr_atop_i,
        output wr_gnt_o, wr_rvalid_o, wr_rdata_o,
        output mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o, mem_atop_o, mem_we_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        input  busy_o,
        output rd_req_i, rd_addr_i,
        input  rd_gnt_o, rd_rvalid_o, rd_rdata_o,
        output wr_req_i, wr_addr_i, wr_wdata_i, wr_strb_i, wr_atop_i,
        input  wr_gnt_o, wr_rvalid_o, wr_rdata_o,
        input  mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o, mem_atop_o, mem_we_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/axi_to_mem_rw_share.sv
// Merges a read-side and a write-side memory request stream onto shared
// single-ported banks. Each bank arbitrates independently, holds its
// payload stable while the bank stalls, and remembers the side of every
// granted request in a small in-order FIFO so responses find their way back.
module axi_to_mem_rw_share #(
    parameter int unsigned NumBanks       = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned MemDataWidth   = 64,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned ArbMode        = 0,
    parameter int unsigned StarveLimit    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    axi_to_mem_rw_share_if.slave  bus
);
    localparam int unsigned StrbWidth = MemDataWidth / 8;
    localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
    localparam int unsigned StarveW   = $clog2(StarveLimit + 1);

    typedef enum logic {
        SideRd = 1'b0,
        SideWr = 1'b1
    } side_e;

    logic [NumBanks-1:0] rd_gnt, wr_gnt, rd_rvalid, wr_rvalid;
    logic [NumBanks-1:0] mem_req, mem_we, pending;

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic                rd_req, wr_req, full, sel_wr, req, hs, pop, head;
        logic                lock_q, armed_q;
        side_e               lock_side_q, rr_q;
        logic [StarveW-1:0]  starve_q;
        logic [CntWidth-1:0] cnt_q, cnt_d, idx;
        logic [MaxOutstanding-1:0] fifo_q, fifo_d;

        assign rd_req = bus.rd_req_i[b];
        assign wr_req = bus.wr_req_i[b];
        assign full   = (cnt_q == CntWidth'(MaxOutstanding));
        assign req    = (rd_req | wr_req) & ~full & ~rst_i;
        assign hs     = req & bus.mem_gnt_i[b];
        assign pop    = bus.mem_rvalid_i[b] & (cnt_q != '0);
        assign head   = fifo_q[0];
        // slot for a new entry once this cycle's pop has shifted the FIFO
        assign idx    = pop ? cnt_q - CntWidth'(1) : cnt_q;

        // side selection: lock wins, then lone requester, then arbitration policy
        always_comb begin
            sel_wr = 1'b0;
            if (lock_q) begin
                sel_wr = (lock_side_q == SideWr);
            end else if (wr_req && !rd_req) begin
                sel_wr = 1'b1;
            end else if (wr_req && rd_req) begin
                if (ArbMode == 0) sel_wr = (rr_q == SideWr);
                else              sel_wr = (starve_q != StarveW'(StarveLimit));
            end
        end

        // route FIFO next state: head at bit 0, pop shifts down, push fills next free slot
        always_comb begin
            fifo_d = fifo_q;
            cnt_d  = cnt_q;
            if (pop) begin
                fifo_d = fifo_q >> 1;
                cnt_d  = cnt_d - CntWidth'(1);
            end
            if (hs) begin
                for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                    if (CntWidth'(i) == idx) fifo_d[i] = sel_wr;
                end
                cnt_d = cnt_d + CntWidth'(1);
            end
        end

        // per-bank state: lock, round-robin pointer, starvation counter, FIFO
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                lock_q      <= 1'b0;
                lock_side_q <= SideRd;
                rr_q        <= SideRd;
                starve_q    <= '0;
                cnt_q       <= '0;
                fifo_q      <= '0;
                armed_q     <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                fifo_q <= fifo_d;
                if (req && !bus.mem_gnt_i[b]) begin
                    lock_q      <= 1'b1;
                    lock_side_q <= sel_wr ? SideWr : SideRd;
                end else if (hs) begin
                    lock_q <= 1'b0;
                end
                if (hs) begin
                    rr_q    <= sel_wr ? SideRd : SideWr;
                    armed_q <= 1'b1;
                    if (!sel_wr) begin
                        starve_q <= '0;
                    end else if (rd_req && starve_q != StarveW'(StarveLimit)) begin
                        starve_q <= starve_q + StarveW'(1);
                    end
                end
            end
        end

        // stale responses right after reset are tolerated; once a new grant
        // has been issued, a response with nothing outstanding is an error
        assert property (@(posedge clk_i) disable iff (rst_i)
                         !(armed_q && bus.mem_rvalid_i[b] && cnt_q == '0));

        assign rd_gnt[b]    = hs & ~sel_wr;
        assign wr_gnt[b]    = hs & sel_wr;
        assign mem_req[b]   = req;
        assign mem_we[b]    = sel_wr & ~rst_i;
        assign rd_rvalid[b] = pop & ~head & ~rst_i;
        assign wr_rvalid[b] = pop & head & ~rst_i;
        assign pending[b]   = (cnt_q != '0) & ~rst_i;

        assign bus.mem_addr_o[b*AddrWidth +: AddrWidth] =
            sel_wr ? bus.wr_addr_i[b*AddrWidth +: AddrWidth]
                   : bus.rd_addr_i[b*AddrWidth +: AddrWidth];
        assign bus.mem_wdata_o[b*MemDataWidth +: MemDataWidth] =
            sel_wr ? bus.wr_wdata_i[b*MemDataWidth +: MemDataWidth] : '0;
        assign bus.mem_strb_o[b*StrbWidth +: StrbWidth] =
            sel_wr ? bus.wr_strb_i[b*StrbWidth +: StrbWidth] : '0;
        assign bus.mem_atop_o[b*6 +: 6] = sel_wr ? bus.wr_atop_i[b*6 +: 6] : '0;
    end

    assign bus.rd_gnt_o    = rd_gnt;
    assign bus.wr_gnt_o    = wr_gnt;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.rd_rvalid_o = rd_rvalid;
    assign bus.wr_rvalid_o = wr_rvalid;
    assign bus.rd_rdata_o  = bus.mem_rdata_i;
    assign bus.wr_rdata_o  = bus.mem_rdata_i;
    assign bus.busy_o      = (|bus.rd_req_i) | (|bus.wr_req_i) | (|pending);

endmodule

// File: tb/tb_axi_to_mem_rw_share.sv
// Bench for axi_to_mem_rw_share: a round-robin instance (b0) and a
// write-priority instance (b1), exercised on bank 0 with a scoreboard of
// expected responses filled at grant time and drained on rvalid.
module tb_axi_to_mem_rw_share;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct packed {
        logic        wr;
        logic [63:0] data;
    } exp_t;
    exp_t exp_q[$];

    axi_to_mem_rw_share_if #(.NumBanks(4), .AddrWidth(32), .MemDataWidth(64)) b0 ();
    axi_to_mem_rw_share_if #(.NumBanks(4), .AddrWidth(32), .MemDataWidth(64)) b1 ();

    axi_to_mem_rw_share #(
        .NumBanks(4), .AddrWidth(32), .MemDataWidth(64),
        .MaxOutstanding(2), .ArbMode(0), .StarveLimit(4)
    ) dut_rr (
        .clk_i(clk), .rst_i(rst), .bus(b0)
    );

    axi_to_mem_rw_share #(
        .NumBanks(4), .AddrWidth(32), .MemDataWidth(64),
        .MaxOutstanding(2), .ArbMode(1), .StarveLimit(4)
    ) dut_wp (
        .clk_i(clk), .rst_i(rst), .bus(b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        b0.rd_req_i[0] = 1'b1;
        b1.wr_req_i[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (b0.rd_gnt_o !== 4'h0 || b0.wr_gnt_o !== 4'h0 || b0.mem_req_o !== 4'h0 ||
            b0.mem_we_o !== 4'h0 || b0.rd_rvalid_o !== 4'h0 || b0.wr_rvalid_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_b0_outs: got gnt %h/%h req %h we %h rv %h/%h expected all 0",
                     b0.rd_gnt_o, b0.wr_gnt_o, b0.mem_req_o, b0.mem_we_o, b0.rd_rvalid_o, b0.wr_rvalid_o);
        end
        checks++;
        if (b1.wr_gnt_o !== 4'h0 || b1.mem_req_o !== 4'h0 || b1.mem_we_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_b1_outs: got gnt %h req %h we %h expected 0", b1.wr_gnt_o, b1.mem_req_o, b1.mem_we_o);
        end
        checks++;
        if (b0.busy_o !== 1'b1 || b1.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_follows: got %b %b expected 1 1", b0.busy_o, b1.busy_o);
        end
        b0.rd_req_i[0] = 1'b0;
        b1.wr_req_i[0] = 1'b0;
        #1;
        checks++;
        if (b0.busy_o !== 1'b0 || b1.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_idle: got %b %b expected 0 0", b0.busy_o, b1.busy_o);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rr_alternate();
        logic        exp_wr;
        logic        pend;
        logic [63:0] pend_d;
        logic [63:0] got_d;
        int          ngr;
        exp_t        e;
        exp_wr = 1'b0;
        pend   = 1'b0;
        pend_d = '0;
        ngr    = 0;
        b0.rd_addr_i[31:0]  = 32'h0000_0100;
        b0.wr_addr_i[31:0]  = 32'h0000_0200;
        b0.wr_wdata_i[63:0] = 64'hDEAD_BEEF_0000_0001;
        b0.wr_strb_i[7:0]   = 8'hFF;
        b0.rd_req_i[0] = 1'b1;
        b0.wr_req_i[0] = 1'b1;
        b0.mem_gnt_i[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            b0.mem_rvalid_i[0]     = pend;
            b0.mem_rdata_i[63:0]   = pend_d;
            if (ngr == 4) begin
                b0.rd_req_i[0] = 1'b0;
                b0.wr_req_i[0] = 1'b0;
            end
            @(negedge clk);
            if (ngr < 4) begin
                checks++;
                if (b0.rd_gnt_o[0] !== !exp_wr || b0.wr_gnt_o[0] !== exp_wr || b0.mem_we_o[0] !== exp_wr ||
                    b0.mem_addr_o[31:0] !== (exp_wr ? 32'h200 : 32'h100)) begin
                    errors++;
                    $display("FAIL rr_grant%0d: got rd %b wr %b we %b addr %h expected wr-side %b",
                             ngr, b0.rd_gnt_o[0], b0.wr_gnt_o[0], b0.mem_we_o[0], b0.mem_addr_o[31:0], exp_wr);
                end
            end
            checks++;
            if (b0.busy_o !== (c <= 4)) begin
                errors++;
                $display("FAIL rr_busy_c%0d: got %b expected %b", c, b0.busy_o, (c <= 4));
            end
            if (b0.rd_rvalid_o[0] || b0.wr_rvalid_o[0]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rr_resp: got unexpected rvalid expected none");
                end else begin
                    e = exp_q.pop_front();
                    got_d = e.wr ? b0.wr_rdata_o[63:0] : b0.rd_rdata_o[63:0];
                    if (b0.wr_rvalid_o[0] !== e.wr || b0.rd_rvalid_o[0] !== !e.wr || got_d !== e.data) begin
                        errors++;
                        $display("FAIL rr_resp: got rd %b wr %b data %h expected wr-side %b data %h",
                                 b0.rd_rvalid_o[0], b0.wr_rvalid_o[0], got_d, e.wr, e.data);
                    end
                end
            end
            if (ngr < 4) begin
                pend_d = 64'h1000 + 64'(ngr);
                exp_q.push_back('{wr: exp_wr, data: pend_d});
                pend   = 1'b1;
                exp_wr = !exp_wr;
                ngr++;
            end else begin
                pend = 1'b0;
            end
            tick();
        end
        b0.mem_rvalid_i[0] = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_drain: got %0d pending expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_write_priority();
        logic [9:0]  seq;
        logic        exp_wr;
        logic        pend;
        logic [63:0] pend_d;
        logic [63:0] got_d;
        exp_t        e;
        seq    = 10'b0111101111;   // bit c = 1: write granted in cycle c
        pend   = 1'b0;
        pend_d = '0;
        b1.rd_addr_i[31:0]  = 32'h0000_0600;
        b1.wr_addr_i[31:0]  = 32'h0000_0700;
        b1.wr_wdata_i[63:0] = 64'h0;
        b1.wr_strb_i[7:0]   = 8'hFF;
        b1.rd_req_i[0] = 1'b1;
        b1.wr_req_i[0] = 1'b1;
        b1.mem_gnt_i[0] = 1'b1;
        for (int c = 0; c < 11; c++) begin
            b1.mem_rvalid_i[0]   = pend;
            b1.mem_rdata_i[63:0] = pend_d;
            if (c == 10) begin
                b1.rd_req_i[0] = 1'b0;
                b1.wr_req_i[0] = 1'b0;
            end
            @(negedge clk);
            exp_wr = seq[c % 10];
            if (c < 10) begin
                checks++;
                if (b1.rd_gnt_o[0] !== !exp_wr || b1.wr_gnt_o[0] !== exp_wr) begin
                    errors++;
                    $display("FAIL wp_grant%0d: got rd %b wr %b expected wr-side %b",
                             c, b1.rd_gnt_o[0], b1.wr_gnt_o[0], exp_wr);
                end
            end
            if (b1.rd_rvalid_o[0] || b1.wr_rvalid_o[0]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wp_resp: got unexpected rvalid expected none");
                end else begin
                    e = exp_q.pop_front();
                    got_d = e.wr ? b1.wr_rdata_o[63:0] : b1.rd_rdata_o[63:0];
                    if (b1.wr_rvalid_o[0] !== e.wr || b1.rd_rvalid_o[0] !== !e.wr || got_d !== e.data) begin
                        errors++;
                        $display("FAIL wp_resp: got rd %b wr %b data %h expected wr-side %b data %h",
                                 b1.rd_rvalid_o[0], b1.wr_rvalid_o[0], got_d, e.wr, e.data);
                    end
                end
            end
            if (c < 10) begin
                pend_d = 64'h2000 + 64'(c);
                exp_q.push_back('{wr: exp_wr, data: pend_d});
                pend = 1'b1;
            end else begin
                pend = 1'b0;
            end
            tick();
        end
        b1.mem_rvalid_i[0] = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wp_drain: got %0d pending expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    // write-priority instance: read alone wins first, then a write arrives
    // while the bank stalls; the held read must still be the one granted
    task automatic test_lock_hold();
        exp_t        e;
        logic [63:0] got_d;
        b1.rd_addr_i[31:0]  = 32'h0000_0300;
        b1.wr_addr_i[31:0]  = 32'h0000_0380;
        b1.wr_wdata_i[63:0] = 64'h5555;
        b1.mem_gnt_i[0] = 1'b0;
        b1.rd_req_i[0]  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) b1.wr_req_i[0] = 1'b1;
            @(negedge clk);
            checks++;
            if (b1.mem_req_o[0] !== 1'b1 || b1.mem_addr_o[31:0] !== 32'h300 || b1.mem_we_o[0] !== 1'b0 ||
                b1.mem_wdata_o[63:0] !== 64'h0 || b1.rd_gnt_o[0] !== 1'b0 || b1.wr_gnt_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL lock_stall_c%0d: got req %b addr %h we %b gnt %b/%b expected 1 00000300 0 0/0",
                         c, b1.mem_req_o[0], b1.mem_addr_o[31:0], b1.mem_we_o[0], b1.rd_gnt_o[0], b1.wr_gnt_o[0]);
            end
            tick();
        end
        b1.mem_gnt_i[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (b1.rd_gnt_o[0] !== 1'b1 || b1.wr_gnt_o[0] !== 1'b0 || b1.mem_addr_o[31:0] !== 32'h300) begin
            errors++;
            $display("FAIL lock_grant: got rd %b wr %b addr %h expected 1 0 00000300",
                     b1.rd_gnt_o[0], b1.wr_gnt_o[0], b1.mem_addr_o[31:0]);
        end
        exp_q.push_back('{wr: 1'b0, data: 64'h3333});
        tick();
        b1.rd_req_i[0]       = 1'b0;
        b1.mem_rvalid_i[0]   = 1'b1;
        b1.mem_rdata_i[63:0] = 64'h3333;
        @(negedge clk);
        checks++;
        if (b1.wr_gnt_o[0] !== 1'b1 || b1.mem_we_o[0] !== 1'b1 || b1.mem_wdata_o[63:0] !== 64'h5555) begin
            errors++;
            $display("FAIL lock_then_wr: got gnt %b we %b wdata %h expected 1 1 5555",
                     b1.wr_gnt_o[0], b1.mem_we_o[0], b1.mem_wdata_o[63:0]);
        end
        exp_q.push_back('{wr: 1'b1, data: 64'h4444});
        e = exp_q.pop_front();
        checks++;
        if (b1.rd_rvalid_o[0] !== !e.wr || b1.wr_rvalid_o[0] !== e.wr || b1.rd_rdata_o[63:0] !== e.data) begin
            errors++;
            $display("FAIL lock_resp_rd: got rd %b wr %b data %h expected 1 0 %h",
                     b1.rd_rvalid_o[0], b1.wr_rvalid_o[0], b1.rd_rdata_o[63:0], e.data);
        end
        tick();
        b1.wr_req_i[0]       = 1'b0;
        b1.mem_rdata_i[63:0] = 64'h4444;
        @(negedge clk);
        e = exp_q.pop_front();
        got_d = b1.wr_rdata_o[63:0];
        checks++;
        if (b1.rd_rvalid_o[0] !== !e.wr || b1.wr_rvalid_o[0] !== e.wr || got_d !== e.data) begin
            errors++;
            $display("FAIL lock_resp_wr: got rd %b wr %b data %h expected 0 1 %h",
                     b1.rd_rvalid_o[0], b1.wr_rvalid_o[0], got_d, e.data);
        end
        tick();
        b1.mem_rvalid_i[0] = 1'b0;
        tick();
    endtask

    task automatic test_outstanding_limit();
        logic [7:0]  exp_req;
        logic [7:0]  rv_sched;
        logic [63:0] ret_q[$];
        logic [63:0] d;
        exp_t        e;
        exp_req  = 8'b0010_0011;
        rv_sched = 8'b1101_0000;
        b0.rd_addr_i[31:0] = 32'h0000_0400;
        b0.mem_gnt_i[0] = 1'b1;
        b0.rd_req_i[0]  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 6) b0.rd_req_i[0] = 1'b0;
            if (rv_sched[c]) begin
                b0.mem_rvalid_i[0]   = 1'b1;
                b0.mem_rdata_i[63:0] = ret_q.pop_front();
            end else begin
                b0.mem_rvalid_i[0] = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (b0.mem_req_o[0] !== exp_req[c] || b0.rd_gnt_o[0] !== exp_req[c]) begin
                errors++;
                $display("FAIL outst_req_c%0d: got req %b gnt %b expected %b",
                         c, b0.mem_req_o[0], b0.rd_gnt_o[0], exp_req[c]);
            end
            if (rv_sched[c]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL outst_resp_c%0d: got empty scoreboard expected entry", c);
                end else begin
                    e = exp_q.pop_front();
                    if (b0.rd_rvalid_o[0] !== 1'b1 || b0.wr_rvalid_o[0] !== 1'b0 || b0.rd_rdata_o[63:0] !== e.data) begin
                        errors++;
                        $display("FAIL outst_resp_c%0d: got rd %b wr %b data %h expected 1 0 %h",
                                 c, b0.rd_rvalid_o[0], b0.wr_rvalid_o[0], b0.rd_rdata_o[63:0], e.data);
                    end
                end
            end
            if (exp_req[c]) begin
                d = 64'h4000 + 64'(c);
                ret_q.push_back(d);
                exp_q.push_back('{wr: 1'b0, data: d});
            end
            tick();
        end
        b0.mem_rvalid_i[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (b0.busy_o !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL outst_drain: got busy %b pending %0d expected 0 0", b0.busy_o, exp_q.size());
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_atomic_route();
        exp_t e;
        b0.wr_addr_i[31:0]  = 32'h0000_0500;
        b0.wr_wdata_i[63:0] = 64'h0000_0000_0000_0007;
        b0.wr_strb_i[7:0]   = 8'h0F;
        b0.wr_atop_i[5:0]   = 6'b100000;   // AtomicLoad, ADD
        b0.wr_req_i[0]  = 1'b1;
        b0.mem_gnt_i[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (b0.wr_gnt_o[0] !== 1'b1 || b0.mem_we_o[0] !== 1'b1 || b0.mem_atop_o[5:0] !== 6'h20 ||
            b0.mem_strb_o[7:0] !== 8'h0F || b0.mem_wdata_o[63:0] !== 64'h7) begin
            errors++;
            $display("FAIL atop_issue: got gnt %b we %b atop %h strb %h wdata %h expected 1 1 20 0f 7",
                     b0.wr_gnt_o[0], b0.mem_we_o[0], b0.mem_atop_o[5:0], b0.mem_strb_o[7:0], b0.mem_wdata_o[63:0]);
        end
        exp_q.push_back('{wr: 1'b1, data: 64'h1234});
        tick();
        b0.wr_req_i[0]       = 1'b0;
        b0.wr_atop_i[5:0]    = 6'h0;
        b0.mem_rvalid_i[0]   = 1'b1;
        b0.mem_rdata_i[63:0] = 64'h1234;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (b0.wr_rvalid_o[0] !== e.wr || b0.rd_rvalid_o[0] !== !e.wr || b0.wr_rdata_o[63:0] !== e.data) begin
            errors++;
            $display("FAIL atop_resp: got wr %b rd %b data %h expected 1 0 %h",
                     b0.wr_rvalid_o[0], b0.rd_rvalid_o[0], b0.wr_rdata_o[63:0], e.data);
        end
        tick();
        b0.mem_rvalid_i[0] = 1'b0;
        tick();
    endtask

    task automatic test_reset_midop();
        exp_t e;
        b0.rd_addr_i[31:0] = 32'h0000_0800;
        b0.wr_addr_i[31:0] = 32'h0000_0900;
        b0.mem_gnt_i[0] = 1'b1;
        b0.rd_req_i[0]  = 1'b1;
        tick();
        tick();
        b0.rd_req_i[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (b0.busy_o !== 1'b0 || b0.mem_req_o[0] !== 1'b0 || b0.rd_gnt_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_reset: got busy %b req %b gnt %b expected 0 0 0",
                     b0.busy_o, b0.mem_req_o[0], b0.rd_gnt_o[0]);
        end
        tick();
        rst = 1'b0;
        b0.mem_rvalid_i[0]   = 1'b1;
        b0.mem_rdata_i[63:0] = 64'hBAD0;
        @(negedge clk);
        checks++;
        if (b0.rd_rvalid_o[0] !== 1'b0 || b0.wr_rvalid_o[0] !== 1'b0 || b0.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stale: got rd %b wr %b busy %b expected 0 0 0",
                     b0.rd_rvalid_o[0], b0.wr_rvalid_o[0], b0.busy_o);
        end
        tick();
        b0.mem_rdata_i[63:0] = 64'hBAD1;
        b0.rd_req_i[0] = 1'b1;
        b0.wr_req_i[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (b0.rd_gnt_o[0] !== 1'b1 || b0.wr_gnt_o[0] !== 1'b0 || b0.rd_rvalid_o[0] !== 1'b0 ||
            b0.wr_rvalid_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_rd_first: got gnt %b/%b rv %b/%b expected 1/0 0/0",
                     b0.rd_gnt_o[0], b0.wr_gnt_o[0], b0.rd_rvalid_o[0], b0.wr_rvalid_o[0]);
        end
        exp_q.push_back('{wr: 1'b0, data: 64'h8888});
        tick();
        b0.rd_req_i[0] = 1'b0;
        b0.wr_req_i[0] = 1'b0;
        b0.mem_rdata_i[63:0] = 64'h8888;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (b0.rd_rvalid_o[0] !== !e.wr || b0.wr_rvalid_o[0] !== e.wr || b0.rd_rdata_o[63:0] !== e.data) begin
            errors++;
            $display("FAIL midrst_resp: got rd %b wr %b data %h expected 1 0 %h",
                     b0.rd_rvalid_o[0], b0.wr_rvalid_o[0], b0.rd_rdata_o[63:0], e.data);
        end
        tick();
        b0.mem_rvalid_i[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (b0.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: got busy %b expected 0", b0.busy_o);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        b0.rd_req_i = '0; b0.rd_addr_i = '0; b0.wr_req_i = '0; b0.wr_addr_i = '0;
        b0.wr_wdata_i = '0; b0.wr_strb_i = '0; b0.wr_atop_i = '0;
        b0.mem_gnt_i = '0; b0.mem_rvalid_i = '0; b0.mem_rdata_i = '0;
        b1.rd_req_i = '0; b1.rd_addr_i = '0; b1.wr_req_i = '0; b1.wr_addr_i = '0;
        b1.wr_wdata_i = '0; b1.wr_strb_i = '0; b1.wr_atop_i = '0;
        b1.mem_gnt_i = '0; b1.mem_rvalid_i = '0; b1.mem_rdata_i = '0;
        test_reset();
        test_rr_alternate();
        test_write_priority();
        test_lock_hold();
        test_outstanding_limit();
        test_atomic_route();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
